// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: state encoding and default width.
package counter_pkg;

    localparam int COUNTER_WIDTH = 8;

    // 2'd3 is unused; the timer treats it as illegal and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_e;

endpackage : counter_pkg

// File: rtl/down_counter_timer.sv
// Programmable down-counter/timer.
// Loads a start value, decrements on each en tick and pulses borrow_out on expiry.
// One-shot mode parks in DONE; periodic mode reloads from the captured start value.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | stopped or never started; count holds, en ignored
// ST_RUN  | counting down on en; expiry at count==0 & en
// ST_DONE | one-shot expired; count holds at 0 until start/stop
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             periodic,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             borrow_q, borrow_d;

    // Register state, count, reload value and the expiry pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
        end
    end

    // Next-state logic; priority is stop > start > en > hold.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        borrow_d = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            // A restart never produces a borrow, even if it lands on an expiry.
            count_d  = load_val;
            reload_d = load_val;
            state_d  = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (en) begin
                        if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            // Zero is the expiry point, so the decrement never wraps.
                            borrow_d = 1'b1;
                            if (periodic) begin
                                count_d = reload_q;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign count      = count_q;
    assign borrow_out = borrow_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: a vector table plus hand-written corner sequences.
module tb_down_counter_timer;
    import counter_pkg::*;

    localparam int W = COUNTER_WIDTH;

    logic         clk;
    logic         rst;
    logic         start;
    logic         stop;
    logic         en;
    logic         periodic;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         borrow_out;
    logic         busy;
    logic         done;

    int n_tests;
    int n_fail;

    typedef struct {
        string        name;
        logic         start;
        logic         stop;
        logic         en;
        logic         periodic;
        logic [W-1:0] load_val;
        logic [W-1:0] exp_count;
        logic         exp_borrow;
        logic         exp_busy;
        logic         exp_done;
    } vec_t;

    vec_t vecs[$];

    down_counter_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .en         (en),
        .periodic   (periodic),
        .load_val   (load_val),
        .count      (count),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [W-1:0] c, input logic b,
                             input logic bz, input logic d);
        check({name, ".count"},  32'(count),      32'(c));
        check({name, ".borrow"}, 32'(borrow_out), 32'(b));
        check({name, ".busy"},   32'(busy),       32'(bz));
        check({name, ".done"},   32'(done),       32'(d));
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic p, input logic e, input logic per,
                         input logic [W-1:0] lv);
        start    = s;
        stop     = p;
        en       = e;
        periodic = per;
        load_val = lv;
    endtask

    task automatic add(input string nm, input logic s, input logic p, input logic e,
                       input logic per, input logic [W-1:0] lv, input logic [W-1:0] c,
                       input logic b, input logic bz, input logic d);
        vec_t v;
        v.name = nm; v.start = s; v.stop = p; v.en = e; v.periodic = per; v.load_val = lv;
        v.exp_count = c; v.exp_borrow = b; v.exp_busy = bz; v.exp_done = d;
        vecs.push_back(v);
    endtask

    initial begin
        int m;
        int en_ticks;
        int borrows;
        int ticks_since;
        logic exp_b;

        n_tests = 0;
        n_fail  = 0;
        drive(0, 0, 0, 0, '0);

        // Reset state, checked while reset is held.
        rst = 1'b1;
        #12;
        check_all("reset", 8'd0, 0, 0, 0);
        rst = 1'b0;
        step();

        //  name       st sp en per lv    count b busy done
        // one-shot from 3
        add("os_start", 1, 0, 0, 0, 8'd3,  8'd3, 0, 1, 0);
        add("os_en1",   0, 0, 1, 0, 8'd99, 8'd2, 0, 1, 0);
        add("os_en2",   0, 0, 1, 0, 8'd99, 8'd1, 0, 1, 0);
        add("os_en3",   0, 0, 1, 0, 8'd99, 8'd0, 0, 1, 0);
        add("os_exp",   0, 0, 1, 0, 8'd99, 8'd0, 1, 0, 1);
        add("os_hold1", 0, 0, 1, 0, 8'd99, 8'd0, 0, 0, 1);
        add("os_hold2", 0, 0, 1, 1, 8'd99, 8'd0, 0, 0, 1);
        // periodic from 2; en in the start cycle is ignored
        add("pr_start", 1, 0, 1, 1, 8'd2,  8'd2, 0, 1, 0);
        add("pr_a1",    0, 0, 1, 1, 8'd50, 8'd1, 0, 1, 0);
        add("pr_a0",    0, 0, 1, 1, 8'd50, 8'd0, 0, 1, 0);
        add("pr_rel1",  0, 0, 1, 1, 8'd50, 8'd2, 1, 1, 0);
        add("pr_b1",    0, 0, 1, 1, 8'd50, 8'd1, 0, 1, 0);
        add("pr_noen",  0, 0, 0, 1, 8'd50, 8'd1, 0, 1, 0);
        add("pr_b0",    0, 0, 1, 1, 8'd50, 8'd0, 0, 1, 0);
        add("pr_rel2",  0, 0, 1, 1, 8'd50, 8'd2, 1, 1, 0);
        add("pr_c1",    0, 0, 1, 1, 8'd50, 8'd1, 0, 1, 0);
        // load 0 one-shot expires on first en, then restart from DONE
        add("z_start",  1, 0, 0, 0, 8'd0,  8'd0, 0, 1, 0);
        add("z_exp",    0, 0, 1, 0, 8'd0,  8'd0, 1, 0, 1);
        add("z_rest",   1, 0, 1, 0, 8'd5,  8'd5, 0, 1, 0);
        add("z_dec",    0, 0, 1, 0, 8'd0,  8'd4, 0, 1, 0);
        // stop beats start; idle ignores en
        add("ss_both",  1, 1, 1, 0, 8'd9,  8'd4, 0, 0, 0);
        add("ss_idle",  0, 0, 1, 1, 8'd9,  8'd4, 0, 0, 0);
        // restart at count 0 with en high never borrows
        add("rs_start", 1, 0, 0, 0, 8'd1,  8'd1, 0, 1, 0);
        add("rs_zero",  0, 0, 1, 0, 8'd0,  8'd0, 0, 1, 0);
        add("rs_rest",  1, 0, 1, 0, 8'd7,  8'd7, 0, 1, 0);
        add("rs_dec",   0, 0, 1, 0, 8'd0,  8'd6, 0, 1, 0);
        // periodic is sampled at expiry: drop it at the expiring tick
        add("ps_start", 1, 0, 0, 1, 8'd1,  8'd1, 0, 1, 0);
        add("ps_zero",  0, 0, 1, 1, 8'd0,  8'd0, 0, 1, 0);
        add("ps_exp",   0, 0, 1, 0, 8'd0,  8'd0, 1, 0, 1);
        // stop from DONE returns to idle
        add("ps_stop",  0, 1, 0, 0, 8'd0,  8'd0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].en, vecs[i].periodic, vecs[i].load_val);
            step();
            check_all(vecs[i].name, vecs[i].exp_count, vecs[i].exp_borrow,
                      vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Full-range periodic with en alternating: 256 en ticks per borrow, none on idle cycles.
        drive(1, 0, 0, 1, 8'hFF);
        step();
        check_all("ff_start", 8'hFF, 0, 1, 0);
        m = 255;
        en_ticks = 0;
        borrows = 0;
        ticks_since = 0;
        for (int c = 0; c < 1040; c++) begin
            drive(0, 0, (c % 2) == 0, 1, 8'h00);
            exp_b = 1'b0;
            if (en) begin
                en_ticks++;
                ticks_since++;
                if (m == 0) begin
                    m = 255;
                    exp_b = 1'b1;
                end else begin
                    m = m - 1;
                end
            end
            step();
            check("ff_count",  32'(count),      32'(m));
            check("ff_borrow", 32'(borrow_out), 32'(exp_b));
            if (borrow_out) begin
                borrows++;
                check("ff_period", 32'(ticks_since), 32'd256);
                check("ff_en_at_borrow", 32'(en), 32'd1);
                ticks_since = 0;
            end
        end
        check("ff_borrows", 32'(borrows), 32'd2);
        check("ff_busy", 32'(busy), 32'd1);

        // Asynchronous reset between edges while running.
        drive(1, 0, 0, 0, 8'd50);
        step();
        drive(0, 0, 1, 0, 8'd0);
        step();
        step();
        check("ar_pre", 32'(count), 32'd48);
        #3;
        rst = 1'b1;
        #1;
        check_all("ar_mid", 8'd0, 0, 0, 0);
        #1;
        rst = 1'b0;
        step();
        check_all("ar_after", 8'd0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_down_counter_timer
